// File: rtl/cls_cmd_issuer_if.sv
// Request/command/result bundle between the parser/rule path, the issuer and the classifier.
// slave = issuer side, master = requester/classifier side.
interface cls_cmd_issuer_if;
  logic         s_valid;
  logic         s_ready;
  logic [103:0] s_tuple;
  logic [7:0]   s_tag;
  logic         u_valid;
  logic         u_ready;
  logic [103:0] u_tuple;
  logic [1:0]   command;
  logic [103:0] tupleData;
  logic         match_in;
  logic         r_valid;
  logic [7:0]   r_tag;
  logic         r_match;
  logic         busy;

  modport slave (
    input  s_valid, s_tuple, s_tag, u_valid, u_tuple, match_in,
    output s_ready, u_ready, command, tupleData, r_valid, r_tag, r_match, busy
  );

  modport master (
    output s_valid, s_tuple, s_tag, u_valid, u_tuple, match_in,
    input  s_ready, u_ready, command, tupleData, r_valid, r_tag, r_match, busy
  );
endinterface

// File: rtl/cls_cmd_issuer.sv
// Classifier issuer: search/update FIFOs, one registered command per cycle, result tagged MATCH_LAT+1 cycles after a search.
// Backpressure: s_ready/u_ready = FIFO not full; updates force UPD_GAP idle cycles.
module cls_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int UPD_GAP    = 3,
  parameter int MATCH_LAT  = 2,
  parameter int SRCH_BURST = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cls_cmd_issuer_if.slave io_if
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int GW = (UPD_GAP > 0) ? $clog2(UPD_GAP + 1) : 1;
  localparam int BW = (SRCH_BURST > 0) ? $clog2(SRCH_BURST + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_INIT  = GW'(UPD_GAP);
  localparam logic [GW-1:0] GAP_LAST  = GW'(1);
  localparam logic [BW-1:0] BURST_MAX = BW'(SRCH_BURST);
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_UPD  = 2'b01;
  localparam logic [1:0] CMD_SRCH = 2'b10;

  typedef enum logic {ST_ISSUE, ST_GAP} state_t;
  typedef struct packed {
    logic       srch;
    logic [7:0] tag;
  } res_t;

  logic [111:0]  r_s_mem [FIFO_DEPTH];
  logic [AW-1:0] r_s_wp, r_s_rp;
  logic [CW-1:0] r_s_cnt;
  logic [103:0]  r_u_mem [FIFO_DEPTH];
  logic [AW-1:0] r_u_wp, r_u_rp;
  logic [CW-1:0] r_u_cnt;

  logic w_s_full, w_s_empty, w_s_push, w_s_pop;
  logic w_u_full, w_u_empty, w_u_push, w_u_pop;
  logic [111:0] w_s_head;
  logic [103:0] w_u_head;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cmd, w_cmd_nxt;
  logic [103:0]  r_tdata, w_tdata_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  logic [BW-1:0] r_burst_cnt, w_burst_nxt;
  res_t          r_pipe [MATCH_LAT+1];
  logic          r_res_vld, r_res_match, w_inflight;
  logic [7:0]    r_res_tag;

  // A full FIFO refuses the write even if it pops in the same cycle.
  assign w_s_full  = (r_s_cnt == FULL_CNT);
  assign w_s_empty = (r_s_cnt == '0);
  assign w_s_push  = io_if.s_valid && !w_s_full;
  assign w_s_head  = r_s_mem[r_s_rp];
  assign w_u_full  = (r_u_cnt == FULL_CNT);
  assign w_u_empty = (r_u_cnt == '0);
  assign w_u_push  = io_if.u_valid && !w_u_full;
  assign w_u_head  = r_u_mem[r_u_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_wp <= '0; r_s_rp <= '0; r_s_cnt <= '0;
      r_u_wp <= '0; r_u_rp <= '0; r_u_cnt <= '0;
    end else begin
      if (w_s_push) r_s_wp <= r_s_wp + 1'b1;
      if (w_s_pop)  r_s_rp <= r_s_rp + 1'b1;
      if (w_s_push && !w_s_pop)      r_s_cnt <= r_s_cnt + 1'b1;
      else if (!w_s_push && w_s_pop) r_s_cnt <= r_s_cnt - 1'b1;
      if (w_u_push) r_u_wp <= r_u_wp + 1'b1;
      if (w_u_pop)  r_u_rp <= r_u_rp + 1'b1;
      if (w_u_push && !w_u_pop)      r_u_cnt <= r_u_cnt + 1'b1;
      else if (!w_u_push && w_u_pop) r_u_cnt <= r_u_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s_push) r_s_mem[r_s_wp] <= {io_if.s_tag, io_if.s_tuple};
    if (w_u_push) r_u_mem[r_u_wp] <= io_if.u_tuple;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = CMD_IDLE;
    w_tdata_nxt = r_tdata;
    w_gap_nxt   = r_gap_cnt;
    w_burst_nxt = r_burst_cnt;
    w_s_pop     = 1'b0;
    w_u_pop     = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        // An update goes first when no search is waiting or searches have used their burst allowance.
        if (!w_u_empty && (w_s_empty || r_burst_cnt == BURST_MAX)) begin
          w_cmd_nxt   = CMD_UPD;
          w_tdata_nxt = w_u_head;
          w_u_pop     = 1'b1;
          w_gap_nxt   = GAP_INIT;
          w_burst_nxt = '0;
          if (UPD_GAP > 0) w_state_nxt = ST_GAP;
        end else if (!w_s_empty) begin
          w_cmd_nxt   = CMD_SRCH;
          w_tdata_nxt = w_s_head[103:0];
          w_s_pop     = 1'b1;
          if (w_u_empty)                   w_burst_nxt = '0;
          else if (r_burst_cnt != BURST_MAX) w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        w_gap_nxt = r_gap_cnt - 1'b1;
        if (r_gap_cnt <= GAP_LAST) w_state_nxt = ST_ISSUE;
      end
      default: w_state_nxt = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ISSUE;
      r_cmd       <= CMD_IDLE;
      r_tdata     <= '0;
      r_gap_cnt   <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_tdata     <= w_tdata_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // r_pipe[k] describes the command that was on the bus k cycles ago.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= MATCH_LAT; i++) r_pipe[i] <= '0;
      r_res_vld   <= 1'b0;
      r_res_tag   <= '0;
      r_res_match <= 1'b0;
    end else begin
      r_pipe[0] <= '{srch: (w_cmd_nxt == CMD_SRCH), tag: w_s_head[111:104]};
      for (int i = 1; i <= MATCH_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_res_vld <= r_pipe[MATCH_LAT].srch;
      if (r_pipe[MATCH_LAT].srch) begin
        r_res_tag   <= r_pipe[MATCH_LAT].tag;
        r_res_match <= io_if.match_in;
      end
    end
  end

  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i <= MATCH_LAT; i++) w_inflight = w_inflight | r_pipe[i].srch;
  end

  assign io_if.s_ready   = !w_s_full;
  assign io_if.u_ready   = !w_u_full;
  assign io_if.command   = r_cmd;
  assign io_if.tupleData = r_tdata;
  assign io_if.r_valid   = r_res_vld;
  assign io_if.r_tag     = r_res_tag;
  assign io_if.r_match   = r_res_match;
  assign io_if.busy      = !w_s_empty || !w_u_empty || (r_state == ST_GAP) || w_inflight;
endmodule

// File: tb/tb_cls_cmd_issuer.sv
// Scoreboard bench for cls_cmd_issuer: acceptances push expectations, a negedge monitor checks commands and results.
module tb_cls_cmd_issuer;
  localparam int FIFO_DEPTH = 4;
  localparam int UPD_GAP    = 3;
  localparam int MATCH_LAT  = 2;
  localparam int SRCH_BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_edge = 0;
  int first_cmd_cyc = -1;
  int rv_count = 0;
  bit saw_both_full = 0;
  bit saw_s_full = 0;

  logic [103:0] exp_s_tup [$];
  logic [103:0] exp_u_tup [$];
  logic [8:0]   exp_res [$];
  int           exp_rcyc [$];
  logic [1:0]   cmd_log [$];
  logic [1:0]   exp_seq [$];
  logic [1:0]   hist_cmd [$];
  logic [103:0] hist_tup [$];

  cls_cmd_issuer_if bus ();

  cls_cmd_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH), .UPD_GAP(UPD_GAP), .MATCH_LAT(MATCH_LAT), .SRCH_BURST(SRCH_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_if(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Classifier reference: the match bit is a fixed function of the searched tuple.
  function automatic logic cls_model(input logic [103:0] t);
    return t[1] ^ t[96];
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.s_valid && bus.s_ready) begin
          exp_s_tup.push_back(bus.s_tuple);
          exp_res.push_back({bus.s_tag, cls_model(bus.s_tuple)});
          acc_edge = cyc + 1;
        end
        if (bus.u_valid && bus.u_ready) exp_u_tup.push_back(bus.u_tuple);
        if (!bus.s_ready && !bus.u_ready) saw_both_full = 1;
        if (!bus.s_ready) saw_s_full = 1;
        cmd_log.push_back(bus.command);
        if (bus.command == 2'b10) begin
          if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
          exp_rcyc.push_back(cyc + MATCH_LAT + 1);
          if (exp_s_tup.size() == 0) chk("search pending", 0, 1);
          else chk("search tupleData", bus.tupleData, exp_s_tup.pop_front());
        end else if (bus.command == 2'b01) begin
          if (exp_u_tup.size() == 0) chk("update pending", 0, 1);
          else chk("update tupleData", bus.tupleData, exp_u_tup.pop_front());
        end else if (bus.command == 2'b11) begin
          chk("command legal", bus.command, 2'b00);
        end
        if (bus.r_valid) begin
          rv_count++;
          if (exp_res.size() == 0) chk("result pending", 0, 1);
          else chk("result tag/match", {bus.r_tag, bus.r_match}, exp_res.pop_front());
          if (exp_rcyc.size() == 0) chk("result cycle pending", 0, 1);
          else chk("result latency", cyc, exp_rcyc.pop_front());
        end
      end
      hist_cmd.push_back(bus.command);
      hist_tup.push_back(bus.tupleData);
      if (hist_cmd.size() > MATCH_LAT + 1) begin
        void'(hist_cmd.pop_front());
        void'(hist_tup.pop_front());
      end
      if (hist_cmd.size() == MATCH_LAT + 1 && hist_cmd[0] == 2'b10)
        bus.match_in = cls_model(hist_tup[0]);
      else
        bus.match_in = 1'($urandom);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_one_s(input logic [7:0] tag, input logic [103:0] tup);
    bit acc;
    acc = 0;
    bus.s_valid = 1'b1; bus.s_tag = tag; bus.s_tuple = tup;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk); acc = bus.s_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("search accept timeout", acc, 1);
  endtask

  task automatic drive_s(input int n, input logic [7:0] tag0, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      logic [7:0] t;
      t = tag0 + 8'(i);
      drive_one_s(t, {13{t}});
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drive_u(input int n, input logic [7:0] tag0, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      logic [7:0] t;
      bit acc;
      t = tag0 + 8'(i);
      acc = 0;
      bus.u_valid = 1'b1; bus.u_tuple = {13{t}};
      for (int k = 0; k < 64 && !acc; k++) begin
        @(negedge clk); acc = bus.u_ready;
        @(posedge clk); #1;
      end
      if (!acc) chk("update accept timeout", acc, 1);
    end
    bus.u_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    bit done;
    done = 0;
    for (int k = 0; k < lim && !done; k++) begin
      @(negedge clk); done = !bus.busy;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({name, " idle"}, done, 1);
  endtask

  task automatic push_seq(input logic [1:0] c, input int n);
    repeat (n) exp_seq.push_back(c);
  endtask

  task automatic check_seq(input string name);
    int s;
    int extra;
    s = -1;
    extra = 0;
    for (int i = 0; i < cmd_log.size(); i++) if (s < 0 && cmd_log[i] != 2'b00) s = i;
    if (s < 0) s = 0;
    for (int j = 0; j < exp_seq.size(); j++) begin
      total++;
      if (s + j >= cmd_log.size() || cmd_log[s+j] !== exp_seq[j]) begin
        bad++;
        $display("FAIL %s[%0d]: got %0b expected %0b", name, j,
                 (s + j < cmd_log.size()) ? cmd_log[s+j] : 2'bxx, exp_seq[j]);
      end
    end
    for (int j = s + exp_seq.size(); j < cmd_log.size(); j++) if (cmd_log[j] != 2'b00) extra++;
    chk({name, " trailing commands"}, extra, 0);
  endtask

  task automatic check_reset(input string name);
    chk({name, " command"},   bus.command,   2'b00);
    chk({name, " tupleData"}, bus.tupleData, 104'h0);
    chk({name, " r_valid"},   bus.r_valid,   1'b0);
    chk({name, " r_tag"},     bus.r_tag,     8'h00);
    chk({name, " r_match"},   bus.r_match,   1'b0);
    chk({name, " busy"},      bus.busy,      1'b0);
    chk({name, " s_ready"},   bus.s_ready,   1'b1);
    chk({name, " u_ready"},   bus.u_ready,   1'b1);
  endtask

  task automatic start_scenario();
    cmd_log.delete();
    exp_seq.delete();
    rv_count = 0;
    saw_s_full = 0;
    saw_both_full = 0;
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_tag = '0; bus.s_tuple = '0;
    bus.u_valid = 1'b0; bus.u_tuple = '0; bus.match_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single search: issued one cycle after acceptance, result three cycles after issue.
    start_scenario();
    first_cmd_cyc = -1;
    drive_one_s(8'h5A, {26{4'hA}});
    bus.s_valid = 1'b0;
    wait_idle("single search", 50);
    chk("single search issue latency", first_cmd_cyc - acc_edge, 1);
    chk("single search result count", rv_count, 1);
    push_seq(2'b10, 1);
    check_seq("single search cmds");

    // Four back-to-back searches.
    start_scenario();
    drive_s(4, 8'h10, 0);
    wait_idle("burst4", 50);
    push_seq(2'b10, 4);
    check_seq("burst4 cmds");
    chk("burst4 result count", rv_count, 4);

    // Update, then four searches queued during its quiet gap.
    start_scenario();
    fork
      drive_u(1, 8'hC0, 0);
      drive_s(4, 8'h30, 1);
    join
    wait_idle("update gap", 60);
    push_seq(2'b01, 1); push_seq(2'b00, UPD_GAP); push_seq(2'b10, 4);
    check_seq("update gap cmds");
    chk("update gap s_ready dropped", saw_s_full, 1);
    chk("update gap result count", rv_count, 4);

    // Starvation bound: streaming searches, update arrives; 8 more searches then the update.
    start_scenario();
    fork
      drive_s(12, 8'h40, 0);
      drive_u(1, 8'hD0, 2);
    join
    wait_idle("starvation", 100);
    push_seq(2'b10, 10); push_seq(2'b01, 1); push_seq(2'b00, UPD_GAP); push_seq(2'b10, 2);
    check_seq("starvation cmds");
    chk("starvation result count", rv_count, 12);

    // Both FIFOs driven to full with valids held.
    start_scenario();
    fork
      drive_s(14, 8'h60, 0);
      drive_u(6, 8'hE0, 0);
    join
    wait_idle("both full", 400);
    chk("both full readies low together", saw_both_full, 1);
    chk("both full result count", rv_count, 14);

    // Reset with searches in flight and FIFOs occupied.
    start_scenario();
    fork
      drive_s(6, 8'h80, 0);
      drive_u(1, 8'hF0, 0);
    join
    chk("midreset busy before", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    exp_s_tup.delete(); exp_u_tup.delete(); exp_res.delete(); exp_rcyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_scenario();
    repeat (20) @(posedge clk);
    #1;
    chk("midreset results after release", rv_count, 0);
    check_seq("midreset cmds after release");

    chk("leftover search tuples", exp_s_tup.size(), 0);
    chk("leftover update tuples", exp_u_tup.size(), 0);
    chk("leftover results", exp_res.size(), 0);
    chk("leftover result cycles", exp_rcyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
